// File: rtl/execute_md_if.sv
// EX-stage bus between the pipeline/hazard logic and the execute stage.
// The master drives operands and control; the slave returns results and stall status.
interface execute_md_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
);
    logic [CTRL_WIDTH-1:0] ALUControlE;
    logic                  ALUSrcE;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] PCE;
    logic [DATA_WIDTH-1:0] ImmExtE;
    logic                  MDValidE;
    logic [2:0]            MDOpE;
    logic                  FlushE;
    logic [DATA_WIDTH-1:0] ResultE;
    logic                  ZeroE;
    logic [DATA_WIDTH-1:0] WriteDataE;
    logic [DATA_WIDTH-1:0] PCTargetE;
    logic                  StallMDE;
    logic                  MDBusyE;

    modport master (
        output ALUControlE, ALUSrcE, ForwardAE, ForwardBE, RD1E, RD2E,
               ResultW, ALUResultM, PCE, ImmExtE, MDValidE, MDOpE, FlushE,
        input  ResultE, ZeroE, WriteDataE, PCTargetE, StallMDE, MDBusyE
    );

    modport slave (
        input  ALUControlE, ALUSrcE, ForwardAE, ForwardBE, RD1E, RD2E,
               ResultW, ALUResultM, PCE, ImmExtE, MDValidE, MDOpE, FlushE,
        output ResultE, ZeroE, WriteDataE, PCTargetE, StallMDE, MDBusyE
    );
endinterface

// File: rtl/execute_md.sv
// RV32 execute stage: forwarding muxes, single-cycle ALU, branch-target adder and an
// iterative radix-2 multiply/divide unit (W+2 cycles in EX) that stalls the front end.
module execute_md #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input logic         clk,
    input logic         rst_n,
    execute_md_if.slave bus
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    // ALU operation encoding shared with the decoder.
    localparam logic [CTRL_WIDTH-1:0] ALU_ADD = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] ALU_SUB = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] ALU_AND = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] ALU_OR  = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] ALU_XOR = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLT = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLL = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] ALU_SRL = CTRL_WIDTH'(7);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } md_op_t;

    logic [W-1:0] srca, wdata, srcb, alu_result;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        srca = bus.RD1E;
        case (bus.ForwardAE)
            2'b01:   srca = bus.ResultW;
            2'b10:   srca = bus.ALUResultM;
            default: ;
        endcase
    end

    always_comb begin
        wdata = bus.RD2E;
        case (bus.ForwardBE)
            2'b01:   wdata = bus.ResultW;
            2'b10:   wdata = bus.ALUResultM;
            default: ;
        endcase
    end

    assign srcb = bus.ALUSrcE ? bus.ImmExtE : wdata;

    always_comb begin
        alu_result = '0;
        case (bus.ALUControlE)
            ALU_ADD: alu_result = srca + srcb;
            ALU_SUB: alu_result = srca - srcb;
            ALU_AND: alu_result = srca & srcb;
            ALU_OR:  alu_result = srca | srcb;
            ALU_XOR: alu_result = srca ^ srcb;
            ALU_SLT: alu_result = {{(W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_SLL: alu_result = srca << srcb[SHW-1:0];
            ALU_SRL: alu_result = srca >> srcb[SHW-1:0];
            default: ;
        endcase
    end

    // ---------------- multiply/divide unit ----------------
    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] count;
    md_op_t               op_q;
    logic                 sign_a, sign_b, b_zero;
    logic [W-1:0]         dividend_q, opb_q;
    logic [2*W-1:0]       acc;

    md_op_t       op_in;
    logic         sa_in, sb_in, accept;
    logic [W-1:0] mag_a, mag_b;

    // Operands come from the forwarding muxes; the immediate never feeds an M-op.
    always_comb begin
        op_in  = md_op_t'(bus.MDOpE);
        sa_in  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && srca[W-1];
        sb_in  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && wdata[W-1];
        mag_a  = sa_in ? -srca : srca;
        mag_b  = sb_in ? -wdata : wdata;
        accept = (state == IDLE) && bus.MDValidE && !bus.FlushE;
    end

    // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide.
    logic [W:0]     mul_sum, rem_shift;
    logic           div_ge;
    logic [2*W-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb_q} : '0);
        rem_shift = {acc[2*W-1:W], acc[W-1]};
        div_ge    = rem_shift >= {1'b0, opb_q};
        if (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
            acc_step = {(div_ge ? W'(rem_shift - {1'b0, opb_q}) : rem_shift[W-1:0]),
                        acc[W-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY: begin
                if (bus.FlushE)                      state_next = IDLE;
                else if (count == CNT_WIDTH'(1))     state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            op_q       <= OP_MUL;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            b_zero     <= 1'b0;
            dividend_q <= '0;
            opb_q      <= '0;
            acc        <= '0;
        end else if (accept) begin
            count      <= CNT_WIDTH'(W);
            op_q       <= op_in;
            sign_a     <= sa_in;
            sign_b     <= sb_in;
            b_zero     <= (wdata == '0);
            dividend_q <= srca;
            opb_q      <= mag_b;
            acc        <= {{W{1'b0}}, mag_a};
        end else if (state == BUSY) begin
            acc   <= acc_step;
            count <= count - CNT_WIDTH'(1);
        end
    end

    // Sign fixup; divide-by-zero bypasses it so the quotient stays all ones.
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo_fixed, rem_fixed, md_result;

    always_comb begin
        prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
        quo_fixed  = b_zero ? '1 : ((sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0]);
        rem_fixed  = b_zero ? dividend_q : (sign_a ? -acc[2*W-1:W] : acc[2*W-1:W]);
        md_result  = prod_fixed[W-1:0];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: md_result = prod_fixed[2*W-1:W];
            OP_DIV, OP_DIVU:              md_result = quo_fixed;
            OP_REM, OP_REMU:              md_result = rem_fixed;
            default: ;
        endcase
    end

    assign bus.ResultE    = (state == DONE && bus.MDValidE) ? md_result : alu_result;
    assign bus.ZeroE      = (alu_result == '0);
    assign bus.WriteDataE = wdata;
    assign bus.PCTargetE  = bus.PCE + bus.ImmExtE;
    // Gated by rst_n so the stall drops the instant reset asserts.
    assign bus.StallMDE   = rst_n && bus.MDValidE && (state != DONE);
    assign bus.MDBusyE    = (state != IDLE);
endmodule

// File: tb/tb_execute_md.sv
// Self-checking bench for execute_md: a spec-level model (plain 64-bit arithmetic and an
// in-flight age counter) checked every cycle, plus directed vectors with literal results.
module tb_execute_md;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_md_if #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) bus ();
    execute_md #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    bit fwd_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                        input logic [31:0] rw, input logic [31:0] rm);
        case (sel)
            2'b01:   return rw;
            2'b10:   return rm;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] ctrl, input logic [31:0] a, b);
        case (ctrl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Compare process: age = cycles since the in-flight M-op was accepted (-1: none).
    int          md_age = -1;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;

    always @(negedge clk) begin
        logic [31:0] sa, wd, sb, alu_exp;
        int cur;
        sa = fwd(bus.ForwardAE, bus.RD1E, bus.ResultW, bus.ALUResultM);
        wd = fwd(bus.ForwardBE, bus.RD2E, bus.ResultW, bus.ALUResultM);
        sb = bus.ALUSrcE ? bus.ImmExtE : wd;
        alu_exp = alu_model(bus.ALUControlE, sa, sb);
        check("model WriteDataE", bus.WriteDataE, wd);
        check("model PCTargetE", bus.PCTargetE, bus.PCE + bus.ImmExtE);
        if (!bus.MDValidE) begin
            check("model ALU ResultE", bus.ResultE, alu_exp);
            check("model ZeroE", {31'b0, bus.ZeroE}, {31'b0, (alu_exp == 32'd0)});
        end
        if (!rst_n) begin
            check("model reset StallMDE", {31'b0, bus.StallMDE}, 32'd0);
            check("model reset MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
            md_age = -1;
        end else begin
            cur = md_age;
            if (cur < 0 && bus.MDValidE) begin
                cur  = 0;
                m_op = bus.MDOpE;
                m_a  = sa;
                m_b  = wd;
            end
            if (cur < 0) begin
                check("model idle StallMDE", {31'b0, bus.StallMDE}, 32'd0);
                check("model idle MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
            end else if (cur <= W) begin
                check("model busy StallMDE", {31'b0, bus.StallMDE}, {31'b0, bus.MDValidE});
                check("model busy MDBusyE", {31'b0, bus.MDBusyE}, (cur > 0) ? 32'd1 : 32'd0);
            end else begin
                check("model done StallMDE", {31'b0, bus.StallMDE}, 32'd0);
                check("model done MDBusyE", {31'b0, bus.MDBusyE}, 32'd1);
                check("model done ResultE", bus.ResultE, md_model(m_op, m_a, m_b));
            end
            md_age = (cur < 0 || bus.FlushE || cur == W + 1) ? -1 : cur + 1;
        end
    end

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name, input bit hold);
        int n;
        @(posedge clk); #1;
        bus.MDValidE    = 1'b1;
        bus.MDOpE       = op;
        bus.FlushE      = 1'b0;
        bus.ALUControlE = 3'd0;
        if (fwd_mode) begin
            bus.ForwardAE = 2'b10; bus.ALUResultM = a;
            bus.ForwardBE = 2'b01; bus.ResultW    = b;
            bus.ALUSrcE   = 1'b1;  bus.ImmExtE    = 32'h0000_1234;
            bus.RD1E      = 32'hDEAD_0001; bus.RD2E = 32'hBEEF_0002;
        end else begin
            bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
            bus.RD1E      = a;     bus.RD2E      = b;
            bus.ALUSrcE   = 1'b0;
        end
        n = 0;
        @(negedge clk);
        check({name, " accept cycle idle"}, {31'b0, bus.MDBusyE}, 32'd0);
        while (bus.StallMDE && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (n == 1) begin
                bus.RD1E       = $urandom;
                bus.RD2E       = $urandom;
                bus.ResultW    = $urandom;
                bus.ALUResultM = $urandom;
                bus.MDOpE      = 3'($urandom);
            end
            @(negedge clk);
        end
        check({name, " stall cycles"}, n, W + 1);
        check({name, " result"}, bus.ResultE, exp);
        if (!hold) begin
            @(posedge clk); #1;
            bus.MDValidE = 1'b0;
            @(negedge clk);
            check({name, " idle after done"}, {31'b0, bus.MDBusyE}, 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [1:0]  fa, fb;
        logic        src;
        logic [31:0] rd1, rd2, rw, rm, imm, exp;
    } alu_vec_t;

    alu_vec_t vecs[8];

    initial begin
        int seen;
        rst_n = 1'b0;
        bus.ALUControlE = 3'd0; bus.ALUSrcE = 1'b0;
        bus.ForwardAE = 2'b00;  bus.ForwardBE = 2'b00;
        bus.RD1E = '0; bus.RD2E = '0; bus.ResultW = '0; bus.ALUResultM = '0;
        bus.PCE = '0;  bus.ImmExtE = '0;
        bus.MDValidE = 1'b1; bus.MDOpE = 3'd0; bus.FlushE = 1'b0;
        #2;
        check("reset StallMDE with MDValidE=1", {31'b0, bus.StallMDE}, 32'd0);
        check("reset MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
        repeat (2) @(posedge clk);
        #1 bus.MDValidE = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Forwarding through the ALU path and the branch-target adder.
        @(posedge clk); #1;
        bus.ForwardAE = 2'b10; bus.ALUResultM = 32'd5; bus.RD1E = 32'd99;
        bus.ForwardBE = 2'b00; bus.RD2E = 32'd3; bus.ALUSrcE = 1'b0; bus.ALUControlE = 3'd0;
        bus.PCE = 32'h0000_0100; bus.ImmExtE = 32'hFFFF_FFF0;
        @(negedge clk);
        check("fwd ResultE", bus.ResultE, 32'd8);
        check("fwd ZeroE", {31'b0, bus.ZeroE}, 32'd0);
        check("fwd StallMDE", {31'b0, bus.StallMDE}, 32'd0);
        check("fwd PCTargetE", bus.PCTargetE, 32'h0000_00F0);
        check("fwd WriteDataE", bus.WriteDataE, 32'd3);

        vecs[0] = '{3'd1, 2'b00, 2'b10, 1'b0, 32'd5, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0};
        vecs[1] = '{3'd2, 2'b01, 2'b00, 1'b0, 32'd0, 32'hFF00, 32'hF0F0, 32'd0, 32'd0, 32'hF000};
        vecs[2] = '{3'd3, 2'b11, 2'b00, 1'b1, 32'h0F, 32'd0, 32'd0, 32'd0, 32'h30, 32'h3F};
        vecs[3] = '{3'd4, 2'b00, 2'b00, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 32'd0, 32'hF0};
        vecs[4] = '{3'd5, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
        vecs[5] = '{3'd6, 2'b00, 2'b00, 1'b1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd4, 32'h10};
        vecs[6] = '{3'd7, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 32'd0, 32'd1};
        vecs[7] = '{3'd0, 2'b00, 2'b01, 1'b0, 32'd20, 32'd0, 32'd10, 32'd0, 32'd0, 32'd30};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.ALUControlE = vecs[i].ctrl; bus.ForwardAE = vecs[i].fa; bus.ForwardBE = vecs[i].fb;
            bus.ALUSrcE = vecs[i].src; bus.RD1E = vecs[i].rd1; bus.RD2E = vecs[i].rd2;
            bus.ResultW = vecs[i].rw; bus.ALUResultM = vecs[i].rm; bus.ImmExtE = vecs[i].imm;
            @(negedge clk);
            check($sformatf("alu vec %0d ResultE", i), bus.ResultE, vecs[i].exp);
            check($sformatf("alu vec %0d ZeroE", i), {31'b0, bus.ZeroE},
                  {31'b0, (vecs[i].exp == 32'd0)});
        end

        // M-extension directed vectors.
        run_md(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3", 1'b0);
        run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         "MUL -1*-1", 1'b0);
        run_md(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min", 1'b0);
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max", 1'b0);
        run_md(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "MULHSU -1*2", 1'b0);
        run_md(3'd2, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, "MULHSU -2*2^31", 1'b0);
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV -7/2", 1'b0);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM -7/2", 1'b0);
        run_md(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2", 1'b0);
        run_md(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         "REM 7/-2", 1'b0);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV overflow", 1'b0);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM overflow", 1'b0);
        run_md(3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, "DIVU 9/0", 1'b0);
        run_md(3'd7, 32'd9,         32'd0,         32'd9,         "REMU 9/0", 1'b0);
        run_md(3'd4, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFFF, "DIV -9/0", 1'b0);
        run_md(3'd6, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, "REM -9/0", 1'b0);
        run_md(3'd5, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, "DIVU max/10", 1'b0);
        run_md(3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5,         "REMU max/10", 1'b0);
        fwd_mode = 1'b1;
        run_md(3'd0, 32'd6,         32'd5,         32'd30,        "MUL forwarded", 1'b0);
        fwd_mode = 1'b0;
        run_md(3'd5, 32'd100,       32'd7,         32'd14,        "DIVU b2b first", 1'b1);
        run_md(3'd5, 32'd100,       32'd9,         32'd11,        "DIVU b2b second", 1'b0);

        // Flush in BUSY cycle 10: back to IDLE, no DONE cycle.
        @(posedge clk); #1;
        bus.MDValidE = 1'b1; bus.MDOpE = 3'd4; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
        bus.RD1E = 32'd100; bus.RD2E = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        bus.FlushE = 1'b1;
        @(negedge clk);
        check("flush cycle StallMDE", {31'b0, bus.StallMDE}, 32'd1);
        check("flush cycle MDBusyE", {31'b0, bus.MDBusyE}, 32'd1);
        @(posedge clk); #1;
        bus.FlushE = 1'b0; bus.MDValidE = 1'b0;
        @(negedge clk);
        check("after flush MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
        seen = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (bus.MDBusyE) seen++;
        end
        check("no DONE after flush", seen, 32'd0);

        // Asynchronous reset mid-BUSY.
        @(posedge clk); #1;
        bus.MDValidE = 1'b1; bus.MDOpE = 3'd0; bus.RD1E = 32'd3; bus.RD2E = 32'd4;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset StallMDE", {31'b0, bus.StallMDE}, 32'd0);
        check("async reset MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
        bus.MDValidE = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("after reset MDBusyE", {31'b0, bus.MDBusyE}, 32'd0);
        run_md(3'd0, 32'd6, 32'd7, 32'd42, "MUL after reset", 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
